spi_sd_master: RTL and testbench
================================

// Module: spi_sd_master
// PURPOSE
//  Parametrised successor of the byte-wide SD SPI controller, generation 2. It drives up to CS_NUM SPI slaves
//  (SD card, flash, ...) in mode 0 and has selectable slow/fast SCLK dividers. It adds an 80-clock init command
//  and a hardware "wait for response" command with a byte-count timeout. Sits on the CPU port router
//  (memory-mapped at 0x2C/0x2D), one clock domain with the CPU core.
// PARAMETERS
//  CS_NUM    2       number of chip-select lines (>=1)
//  DIV_SLOW  64      SCLK half-period in clocks, init/slow mode (>=1)
//  DIV_FAST  1       SCLK half-period in clocks, fast mode (>=1)
//  TIMEOUT   256     max bytes polled by WAIT before timeout flag (>=1)
// PORTS
//  clock       in   1        system clock; all logic on posedge
//  reset       in   1        synchronous, active-high reset
//  sd_signal   in   1        1-cycle command strobe
//  sd_cmd      in   3        0 XFER, 1 CS_ON, 2 CS_OFF, 3 INIT, 4 WAIT; 5..7 ignored
//  sd_out      in   8        byte to transmit (XFER)
//  cs_sel      in   clog2(CS_NUM) (min 1)  slave index for CS_ON
//  fast        in   1        1: DIV_FAST, 0: DIV_SLOW; latched at accept
//  sd_din      out  8        last received byte
//  sd_busy     out  1        command in progress
//  sd_timeout  out  1        last WAIT exhausted TIMEOUT bytes
//  SPI_CS      out  CS_NUM   active-low selects
//  SPI_SCLK    out  1        serial clock, idle low
//  SPI_MISO    in   1        serial data in
//  SPI_MOSI    out  1        serial data out, idle high
// BEHAVIOUR
//  Reset: SPI_CS all 1, SPI_SCLK 0, SPI_MOSI 1, sd_din 8'hFF, sd_busy 0, sd_timeout 0, state IDLE.
//   Reset mid-command aborts at once; outputs take reset values on the next edge.
//  Accept: sd_signal=1 && sd_busy=0 in cycle N. sd_signal while busy, and cmds 5..7, are ignored (no busy).
//   Divider H = fast ? DIV_FAST : DIV_SLOW, latched at N; INIT always uses DIV_SLOW.
//  States: IDLE, SHIFT (XFER/WAIT byte), INIT, CSOP.
//  CS_ON/CS_OFF (CSOP): sd_busy=1 for cycle N+1 only.
//   CS_ON: SPI_CS[cs_sel]=0, others 1; cs_sel>=CS_NUM gives all 1.
//   CS_OFF: all 1. CS is not changed by XFER/WAIT.
//  XFER (SHIFT), mode 0, MSB first:
//   - N+1: sd_busy=1 and MOSI=bit7.
//   - SCLK rises at N+1+H*(2k+1) and samples MISO; falls at N+1+H*(2k+2), after which MOSI takes the next bit; k=0..7.
//   - At N+1+16H: sd_din = received byte, sd_busy=0, MOSI=1, SCLK=0. sd_busy is high for exactly 16H cycles.
//  INIT: forces SPI_CS all 1, MOSI=1, 80 SCLK periods at DIV_SLOW; busy 160*DIV_SLOW cycles; SPI_CS stays all 1 after.
//  WAIT: at accept, sd_timeout<=0 and byte counter<=0. Repeats XFER of 8'hFF, back-to-back with no idle cycle.
//   - After each byte: sd_din updated and counter+1.
//   - Received byte != 8'hFF: done, sd_timeout=0.
//   - Else counter==TIMEOUT: done, sd_timeout=1.
//   - Otherwise: next byte.
//   - Busy drops with the final sd_din update. Counter width clog2(TIMEOUT+1); it never wraps.
//  sd_timeout holds until the next WAIT accept or reset. sd_din holds between commands.
//  The same-cycle accept check uses registered sd_busy; a strobe in the cycle busy falls is accepted.
// TESTING
//  1 reset held 3 cycles mid-XFER -> next edge: CS=2'b11, SCLK=0, MOSI=1, sd_din=FF, busy=0, timeout=0
//  2 fast=1, DIV_FAST=2, MISO=MOSI loopback, XFER 8'hA5 -> 8 SCLK rises, busy high exactly 32 cycles, sd_din=A5
//  3 CS_ON cs_sel=1 -> CS=2'b01, busy 1 cycle; CS_OFF -> 2'b11; CS_ON cs_sel=0 then XFER -> CS stays 2'b10
//  4 INIT with DIV_SLOW=4 -> 80 SCLK rises, CS=2'b11 and MOSI=1 throughout, busy 640 cycles
//  5 WAIT, TIMEOUT=4: MISO stuck 1 -> 4 bytes, timeout=1, sd_din=FF; MISO=0 from byte 2 -> 2 bytes, timeout=0, sd_din=00
//  6 strobe XFER 8'h11 while busy with XFER 8'h3C -> ignored; only 3C shifted; cmd 7 -> busy stays 0

Source files
------------

// File: rtl/spi_sd_master.sv
// spi_sd_master: mode-0 SPI master with chip selects, 80-clock init and hardware response polling
module spi_sd_master #(
   parameter int CS_NUM   = 2,
   parameter int DIV_SLOW = 64,
   parameter int DIV_FAST = 1,
   parameter int TIMEOUT  = 256
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      sd_signal,
   input  logic [2:0]                                sd_cmd,
   input  logic [7:0]                                sd_out,
   input  logic [(CS_NUM > 1 ? $clog2(CS_NUM) : 1)-1:0] cs_sel,
   input  logic                                      fast,
   output logic [7:0]                                sd_din,
   output logic                                      sd_busy,
   output logic                                      sd_timeout,
   output logic [CS_NUM-1:0]                         SPI_CS,
   output logic                                      SPI_SCLK,
   input  logic                                      SPI_MISO,
   output logic                                      SPI_MOSI
);
   localparam int DMAX = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
   localparam int DW   = $clog2(DMAX + 1);
   localparam int CW   = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_INIT, S_CSOP} state_t;
   state_t            r_state, w_next;
   logic [DW-1:0]     r_div, r_h;
   logic [7:0]        r_half, r_tx, r_rx, r_din;
   logic [CW-1:0]     r_cnt, w_cnt_nx;
   logic [CS_NUM-1:0] r_cs, w_cs_on;
   logic              r_wait, r_sclk, r_mosi, r_to;
   logic              w_acc, w_tick, w_end, w_more, w_busy;
   assign w_acc    = sd_signal && r_state == S_IDLE && sd_cmd <= 3'd4;
   assign w_tick   = r_div == r_h - 1'b1;
   assign w_end    = w_tick && r_half == (r_state == S_INIT ? 8'd159 : 8'd15);
   assign w_cnt_nx = r_cnt + 1'b1;
   assign w_more   = r_wait && r_rx == 8'hFF && w_cnt_nx != CW'(TIMEOUT);
   assign w_cs_on  = ~(CS_NUM'(1) << cs_sel);
   assign sd_din     = r_din;
   assign sd_busy    = w_busy;
   assign sd_timeout = r_to;
   assign SPI_CS     = r_cs;
   assign SPI_SCLK   = r_sclk;
   assign SPI_MOSI   = r_mosi;
   // state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end
   // next state: a WAIT poll keeps SHIFT running until a response byte or the byte budget ends it
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_next = sd_cmd == 3'd3 ? S_INIT : (sd_cmd == 3'd1 || sd_cmd == 3'd2) ? S_CSOP : S_SHIFT;
         S_SHIFT: if (w_end && !w_more) w_next = S_IDLE;
         S_INIT:  if (w_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   // outputs decoded from the state register
   always_comb w_busy = r_state != S_IDLE;
   // datapath: latch command on accept, then step one SCLK half-period every r_h clocks
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cs   <= '1;
         r_sclk <= 1'b0;
         r_mosi <= 1'b1;
         r_din  <= 8'hFF;
         r_to   <= 1'b0;
         r_div  <= '0;
         r_h    <= '0;
         r_half <= '0;
         r_tx   <= '0;
         r_rx   <= '0;
         r_cnt  <= '0;
         r_wait <= 1'b0;
      end else if (w_acc) begin
         r_div  <= '0;
         r_half <= '0;
         r_h    <= fast && sd_cmd != 3'd3 ? DW'(DIV_FAST) : DW'(DIV_SLOW);
         r_tx   <= sd_cmd == 3'd0 ? sd_out : 8'hFF;
         r_mosi <= sd_cmd == 3'd0 ? sd_out[7] : 1'b1;
         r_wait <= sd_cmd == 3'd4;
         if (sd_cmd == 3'd4) begin
            r_to  <= 1'b0;
            r_cnt <= '0;
         end
         if (sd_cmd == 3'd1) r_cs <= w_cs_on;
         else if (sd_cmd == 3'd2 || sd_cmd == 3'd3) r_cs <= '1;
      end else if (r_state == S_SHIFT || r_state == S_INIT) begin
         if (!w_tick) r_div <= r_div + 1'b1;
         else begin
            r_div  <= '0;
            r_half <= w_end && w_more ? 8'd0 : r_half + 1'b1;
            r_sclk <= !r_half[0];
            if (!r_half[0]) r_rx <= {r_rx[6:0], SPI_MISO};
            else if (r_state == S_SHIFT && !w_end) begin
               r_tx   <= {r_tx[6:0], 1'b1};
               r_mosi <= r_tx[6];
            end else if (r_state == S_SHIFT) begin
               r_din  <= r_rx;
               r_mosi <= 1'b1;
               r_tx   <= 8'hFF;
               if (r_wait) r_cnt <= w_cnt_nx;
               if (r_wait && !w_more) r_to <= r_rx == 8'hFF;
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_sd_master.sv
// tb_spi_sd_master: scoreboard bench; stimulus queues expected command results, a monitor checks each busy window
module tb_spi_sd_master;
   typedef struct packed {
      logic [7:0]  din;
      logic        to;
      logic [1:0]  cs;
      logic [15:0] len;
      logic [7:0]  rises;
      logic        mlow;
   } exp_t;
   logic       clock = 1'b0, reset = 1'b1, sd_signal = 1'b0, fast = 1'b0;
   logic [2:0] sd_cmd = 3'd0;
   logic [7:0] sd_out = 8'd0;
   logic [0:0] cs_sel = 1'b0;
   logic [1:0] miso_mode = 2'd0;
   logic [7:0] sd_din;
   logic       sd_busy, sd_timeout, SPI_SCLK, SPI_MISO, SPI_MOSI;
   logic [1:0] SPI_CS;
   exp_t       q[$];
   string      qn[$];
   int         n_chk = 0, n_pass = 0;
   assign SPI_MISO = miso_mode == 2'd1 ? SPI_MOSI : miso_mode == 2'd2 ? 1'b0 : 1'b1;
   spi_sd_master #(.CS_NUM(2), .DIV_SLOW(4), .DIV_FAST(2), .TIMEOUT(4)) dut (
      .clock(clock), .reset(reset), .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
      .cs_sel(cs_sel), .fast(fast), .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout),
      .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK), .SPI_MISO(SPI_MISO), .SPI_MOSI(SPI_MOSI));
   always #5 clock = ~clock;
   task automatic chk(string n, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask
   task automatic push(string n, logic [7:0] din, logic to, logic [1:0] cs, int len, int rises, logic mlow);
      exp_t e;
      e.din = din; e.to = to; e.cs = cs; e.len = 16'(len); e.rises = 8'(rises); e.mlow = mlow;
      q.push_back(e);
      qn.push_back(n);
   endtask
   task automatic issue(logic [2:0] c, logic [7:0] d, logic s, logic f);
      @(negedge clock);
      sd_cmd = c; sd_out = d; cs_sel = s; fast = f; sd_signal = 1'b1;
      @(negedge clock);
      sd_signal = 1'b0;
   endtask
   task automatic wait_done(string n, int bound);
      int k = 0;
      while ((q.size() != 0 || sd_busy) && k < bound) begin
         @(negedge clock);
         #1;
         k++;
      end
      chk({n, "_done"}, int'(q.size() == 0 && !sd_busy), 1);
   endtask
   task automatic check_reset(string n);
      chk({n, "_cs"}, int'(SPI_CS), 3);
      chk({n, "_sclk"}, int'(SPI_SCLK), 0);
      chk({n, "_mosi"}, int'(SPI_MOSI), 1);
      chk({n, "_din"}, int'(sd_din), 8'hFF);
      chk({n, "_busy"}, int'(sd_busy), 0);
      chk({n, "_timeout"}, int'(sd_timeout), 0);
   endtask
   // monitor: measure each busy window and compare against the oldest queued expectation when busy falls
   initial begin
      int blen = 0, rcnt = 0;
      logic mlow = 1'b0, cvar = 1'b0, pb = 1'b0, ps = 1'b0;
      logic [1:0] c0 = 2'b11;
      exp_t e;
      string n;
      forever begin
         @(negedge clock);
         if (reset) begin
            blen = 0; rcnt = 0; mlow = 1'b0; cvar = 1'b0; pb = 1'b0; ps = 1'b0;
         end else begin
            if (sd_busy) begin
               if (!pb) c0 = SPI_CS;
               else if (SPI_CS != c0) cvar = 1'b1;
               blen++;
               if (SPI_SCLK && !ps) rcnt++;
               if (!SPI_MOSI) mlow = 1'b1;
            end
            if (pb && !sd_busy) begin
               if (q.size() == 0) chk("unexpected_command", 1, 0);
               else begin
                  e = q.pop_front();
                  n = qn.pop_front();
                  chk({n, "_din"}, int'(sd_din), int'(e.din));
                  chk({n, "_timeout"}, int'(sd_timeout), int'(e.to));
                  chk({n, "_cs"}, int'(SPI_CS), int'(e.cs));
                  chk({n, "_busy_len"}, blen, int'(e.len));
                  chk({n, "_sclk_rises"}, rcnt, int'(e.rises));
                  chk({n, "_mosi_low_seen"}, int'(mlow), int'(e.mlow));
                  chk({n, "_cs_stable"}, int'(cvar), 0);
                  chk({n, "_sclk_idle"}, int'(SPI_SCLK), 0);
                  chk({n, "_mosi_idle"}, int'(SPI_MOSI), 1);
               end
               blen = 0; rcnt = 0; mlow = 1'b0; cvar = 1'b0;
            end
            pb = sd_busy;
            ps = SPI_SCLK;
         end
      end
   end
   // stimulus: directed commands, each with its hand-computed outcome queued first
   initial begin
      repeat (3) @(negedge clock);
      check_reset("por");
      reset = 1'b0;
      miso_mode = 2'd1;
      issue(3'd0, 8'h5A, 1'b0, 1'b0);
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset("mid_reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      push("xfer_a5_fast", 8'hA5, 1'b0, 2'b11, 32, 8, 1'b1);
      issue(3'd0, 8'hA5, 1'b0, 1'b1);
      wait_done("xfer_a5_fast", 100);
      push("cs_on_1", 8'hA5, 1'b0, 2'b01, 1, 0, 1'b0);
      issue(3'd1, 8'h00, 1'b1, 1'b0);
      wait_done("cs_on_1", 10);
      push("cs_off", 8'hA5, 1'b0, 2'b11, 1, 0, 1'b0);
      issue(3'd2, 8'h00, 1'b0, 1'b0);
      wait_done("cs_off", 10);
      push("cs_on_0", 8'hA5, 1'b0, 2'b10, 1, 0, 1'b0);
      issue(3'd1, 8'h00, 1'b0, 1'b0);
      wait_done("cs_on_0", 10);
      push("xfer_3c", 8'h3C, 1'b0, 2'b10, 32, 8, 1'b1);
      issue(3'd0, 8'h3C, 1'b0, 1'b1);
      repeat (5) @(negedge clock);
      issue(3'd0, 8'h11, 1'b0, 1'b1);
      wait_done("xfer_3c", 100);
      issue(3'd7, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("cmd7_busy", int'(sd_busy), 0);
         @(negedge clock);
      end
      push("init", 8'h3C, 1'b0, 2'b11, 640, 80, 1'b0);
      issue(3'd3, 8'h00, 1'b0, 1'b1);
      wait_done("init", 1000);
      miso_mode = 2'd0;
      push("wait_timeout", 8'hFF, 1'b1, 2'b11, 128, 32, 1'b0);
      issue(3'd4, 8'h00, 1'b0, 1'b1);
      wait_done("wait_timeout", 300);
      miso_mode = 2'd1;
      push("xfer_slow_hold", 8'hA5, 1'b1, 2'b11, 64, 8, 1'b1);
      issue(3'd0, 8'hA5, 1'b0, 1'b0);
      wait_done("xfer_slow_hold", 200);
      miso_mode = 2'd0;
      push("wait_resp", 8'h00, 1'b0, 2'b11, 64, 16, 1'b0);
      issue(3'd4, 8'h00, 1'b0, 1'b1);
      repeat (32) @(negedge clock);
      miso_mode = 2'd2;
      wait_done("wait_resp", 200);
      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
